// File: rtl/seg_scan_pkg.sv
// seg_scan_pkg: shared FSM states, conversion constants, and 7-segment cathode codes for seg_scan_controller
package seg_scan_pkg;
  typedef enum logic [1:0] {IDLE, CONVERT, LOAD} state_t;
  localparam logic [13:0] MAX_VAL = 14'd9999;
  localparam logic [3:0] CONV_CYCLES = 4'd14;
  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  // double-dabble correction: every BCD nibble >= 5 gets +3 before the shift
  function automatic logic [15:0] bcd_adj(input logic [15:0] b);
    logic [15:0] r;
    r = b;
    for (int i = 0; i < 4; i++) r[4*i +: 4] = b[4*i +: 4] >= 4'd5 ? b[4*i +: 4] + 4'd3 : b[4*i +: 4];
    return r;
  endfunction
endpackage

// File: rtl/seg_scan_if.sv
// seg_scan_if: CPU result bus handshake into the display sequencer
interface seg_scan_if;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        done;
  logic        overflow;
  modport master (output in_valid, in_data, input in_ready, done, overflow);
  modport slave (input in_valid, in_data, output in_ready, done, overflow);
endinterface

// File: rtl/bcd_to_seg.sv
// bcd_to_seg: 4-bit BCD digit to active-low {g,f,e,d,c,b,a} cathode pattern, purely combinational
module bcd_to_seg
  import seg_scan_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);
    always_comb
        case (bcd)
            4'd0: seg = SEG_0;
            4'd1: seg = SEG_1;
            4'd2: seg = SEG_2;
            4'd3: seg = SEG_3;
            4'd4: seg = SEG_4;
            4'd5: seg = SEG_5;
            4'd6: seg = SEG_6;
            4'd7: seg = SEG_7;
            4'd8: seg = SEG_8;
            4'd9: seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
endmodule

// File: rtl/seg_scan_controller.sv
// seg_scan_controller: accepts a value, converts it to BCD by iterative double-dabble and scans it onto a 4-digit 7-seg.
// Optional `SEG_LEADING_ZERO_BLANK_EN blanks leading-zero digit slots.
module seg_scan_controller
  import seg_scan_pkg::*;
#(
    parameter int REFRESH_DIV = 50000,
    parameter int CNT_W = 16
) (
    input  logic       clk,
    input  logic       reset,
    seg_scan_if.slave  bus,
    output logic [3:0] anode,
    output logic [6:0] cathode
);
    state_t state, state_d;
    logic [13:0] bin;
    logic [15:0] bcd, disp;
    logic [3:0] cnt, digit;
    logic [1:0] digit_idx;
    logic [CNT_W-1:0] presc;
    logic [6:0] seg;
    logic in_ready, done, overflow, lit, wrap;
    assign bus.in_ready = in_ready;
    assign bus.done = done;
    assign bus.overflow = overflow;
    assign wrap = presc == CNT_W'(REFRESH_DIV - 1);
    // slot 0 is the thousands digit, so the shift walks down from bit 12
    assign digit = 4'(disp >> {~digit_idx, 2'b00});
`ifdef SEG_LEADING_ZERO_BLANK_EN
    assign lit = digit_idx == 2'd3 || (disp >> {~digit_idx, 2'b00}) != 16'd0;
`else
    assign lit = 1'b1;
`endif
    bcd_to_seg u_seg (.bcd(digit), .seg(seg));
    always_comb begin
        in_ready = state == IDLE;
        done = state == LOAD;
        state_d = state == IDLE ? (bus.in_valid ? CONVERT : IDLE)
                : state == CONVERT ? (cnt == 4'(CONV_CYCLES - 1) ? LOAD : CONVERT) : IDLE;
    end
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state <= IDLE;
            bin <= '0;
            bcd <= '0;
            cnt <= '0;
            disp <= '0;
            overflow <= 1'b0;
            presc <= '0;
            digit_idx <= '0;
            anode <= 4'b1111;
            cathode <= SEG_BLANK;
        end else begin
            state <= state_d;
            presc <= wrap ? '0 : presc + 1'b1;
            digit_idx <= digit_idx + 2'(wrap);
            anode <= lit ? ~(4'b1000 >> digit_idx) : 4'b1111;
            cathode <= seg;
            if (state == IDLE && bus.in_valid) begin
                bin <= bus.in_data > 32'(MAX_VAL) ? MAX_VAL : bus.in_data[13:0];
                bcd <= '0;
                cnt <= '0;
                overflow <= bus.in_data > 32'(MAX_VAL);
            end else if (state == CONVERT) begin
                {bcd, bin} <= {bcd_adj(bcd), bin} << 1;
                cnt <= cnt + 1'b1;
            end
            if (state == LOAD) disp <= bcd;
        end
endmodule
